pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-state controller for the pong datapath. It produces the 2-bit `game_state` consumed by the ball speed/position logic and the display, and it watches the ball position for misses. It keeps both players' scores, arbitrates serves and declares the match over. It runs on the same frame clock as the ball logic and sits between the paddle buttons and the ball/score display blocks.

## Interface
Parameters:
- `LEFT_MISS`, 10'd140: ball_x strictly below this = P1 missed.
- `RIGHT_MISS`, 10'd500: ball_x + `BALL_WIDTH` strictly above this = P2 missed.
- `BALL_WIDTH`, 10'd5: ball size in pixels.
- `WIN_SCORE`, 4'd5: points needed to win; legal range 1..15.

Ports:
- `clk`, in, 1: frame clock, shared with the ball logic.
- `reset`, in, 1: asynchronous, active-low.
- `p1u`, `p1d`, `p2u`, `p2d`, in, 1 each: paddle buttons, active-low.
- `restart_n`, in, 1: new-match button, active-low.
- `ball_x`, `ball_y`, in, 10 each: current ball position.
- `speed_curr_x`, in, 10: registered ball x speed, two's complement.
- `game_state`, out, 2: 0 = p1_serve, 1 = p2_serve, 2 = playing, 3 = done.
- `p1_score`, `p2_score`, out, 4 each: scores.
- `point_p1`, `point_p2`, out, 1 each: one-cycle pulse when that player scores.
- `winner`, out, 2: 0 = none, 1 = P1, 2 = P2.
- `rally_cnt`, out, 8: paddle hits in the current rally (feature-gated).
- `max_rally`, out, 8: longest rally this match (feature-gated).

## Operation
- All outputs are registered.
- Reset values: `game_state` = p1_serve, both scores 0, pulses 0, `winner` 0, `rally_cnt`/`max_rally` 0, serve arm flag clear.
- Serve arming: on entry to a serve state the arm flag clears. It sets only after a cycle in which both of the server's buttons read high. A button held through a point therefore cannot re-serve.
- p1_serve, armed, and `p1u` = 0 or `p1d` = 0 → playing.
- p2_serve, armed, and `p2u` = 0 or `p2d` = 0 → playing.
- Buttons of the non-serving player are ignored in serve states.
- Playing, left miss (`ball_x` < `LEFT_MISS`):
  - `p2_score` increments and `point_p2` pulses.
  - If the new score equals `WIN_SCORE` → done with `winner` = 2; otherwise → p1_serve (the conceding player serves).
- Playing, right miss (`ball_x` + `BALL_WIDTH` > `RIGHT_MISS`, 10-bit add):
  - `p1_score` increments and `point_p1` pulses.
  - If the new score equals `WIN_SCORE` → done with `winner` = 1; otherwise → p2_serve.
- Simultaneous left and right miss: the left miss wins and exactly one point is awarded.
- Scores never exceed `WIN_SCORE` and do not wrap.
- Done:
  - State, scores and `winner` hold.
  - A falling edge of `restart_n` (registered previous value 1, current value 0) clears scores and `winner` and → p1_serve with arm flag clear.
  - `restart_n` is ignored in every other state.
- `ball_y` is unused except for the feature below. It is kept on the port list for display/debug taps.

## Timing
- Every transition takes effect at the clk edge after the condition is sampled; latency is one cycle.
- Serve press is sampled in the same cycle in which the ball logic latches the serve speed. `game_state` = playing appears on the next edge, in step with the ball's nonzero speed.
- Miss detection uses the registered `ball_x`. The point, the state change and the pulse all appear on the same edge.
- Pulses last exactly one cycle.
- Reset mid-rally or while in done returns everything to reset values immediately (asynchronous). Scores and rally history are lost.
- The miss thresholds stay correct for |speed| ≤ 10. `ball_x` cannot underflow past 0 before it is caught at 139.

## Configuration
- Macro: `PONG_RALLY_CNT_EN`.
- Defined:
  - In playing, a change of `speed_curr_x` bit 9 from the previous cycle increments `rally_cnt`, saturating at 255.
  - On a point, `max_rally` updates to max(`max_rally`, `rally_cnt`) and `rally_cnt` clears, both on the point edge.
  - `max_rally` clears on restart and on reset.
- Undefined: `rally_cnt` and `max_rally` are tied to 0 and no sign-tracking register exists.

## Test plan
- Reset, then `p1d` = 0 for one cycle → `game_state` 0 → 2 on the next edge. Holding `p1d` low afterwards has no effect.
- Playing, drive `ball_x` = 139 → `p2_score` = 1, `point_p2` high for one cycle, `game_state` = 0. Keep `p1u` held low from before the point → no serve until it is released and pressed again.
- Playing, `ball_x` = 496 → `p1_score` + 1, `game_state` = 1. Drive `ball_x` = 495 instead → no point.
- Score P1 five times with `WIN_SCORE` = 5 → `game_state` = 3, `winner` = 1, `p1_score` = 5. Further misses and serve buttons → no change.
- In done, hold `restart_n` low from entry → no restart. Release it, then press → scores 0, `winner` 0, `game_state` = 0.
- With `PONG_RALLY_CNT_EN`, toggle the `speed_curr_x` sign three times, then miss → `max_rally` = 3 and `rally_cnt` = 0. Next rally with 1 hit → `max_rally` stays 3. Assert reset mid-rally → all outputs return to reset values.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl -- game-state controller for the pong datapath.
//
// Tracks whose serve it is, detects misses from the registered ball
// position, keeps both scores, pulses a point strobe and declares the match
// winner. All outputs come straight from registers.
//
// Optional feature macro: PONG_RALLY_CNT_EN
//   When defined, paddle hits (sign flips of the ball x speed while playing)
//   are counted per rally, and the longest rally of the match is kept.
//   When undefined, rally_cnt and max_rally are tied to 0.
//
// Ports:
//   clk                  frame clock, shared with the ball logic
//   reset                asynchronous, active-low reset
//   p1u/p1d/p2u/p2d      paddle buttons, active-low
//   restart_n            new-match button, active-low (falling edge in done)
//   ball_x, ball_y       ball position (ball_y is a pass-through tap only)
//   speed_curr_x         registered ball x speed, two's complement
//   game_state           0 p1_serve, 1 p2_serve, 2 playing, 3 done
//   p1_score, p2_score   scores, saturate at WIN_SCORE
//   point_p1, point_p2   one-cycle pulse on a point
//   winner               0 none, 1 P1, 2 P2
//   rally_cnt, max_rally hits in current rally / longest rally this match

module pong_game_ctrl #(
    parameter logic [9:0] LEFT_MISS  = 10'd140,
    parameter logic [9:0] RIGHT_MISS = 10'd500,
    parameter logic [9:0] BALL_WIDTH = 10'd5,
    parameter logic [3:0] WIN_SCORE  = 4'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1u,
    input  logic       p1d,
    input  logic       p2u,
    input  logic       p2d,
    input  logic       restart_n,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] speed_curr_x,
    output logic [1:0] game_state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       point_p1,
    output logic       point_p2,
    output logic [1:0] winner,
    output logic [7:0] rally_cnt,
    output logic [7:0] max_rally
);

    typedef enum logic [1:0] {
        P1_SERVE = 2'd0,
        P2_SERVE = 2'd1,
        PLAYING  = 2'd2,
        DONE     = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] p1_score_q, p1_score_d;
    logic [3:0] p2_score_q, p2_score_d;
    logic       point_p1_q, point_p1_d;
    logic       point_p2_q, point_p2_d;
    logic [1:0] winner_q, winner_d;
    logic       arm_q, arm_d;
    logic       restart_prev_q;

    logic [9:0] ball_right;
    logic       left_miss, right_miss, restart_fall;
    logic [3:0] p1_inc, p2_inc;

    // ball_y and the low speed bits are deliberately unobserved here.
    logic       unused_inputs;
    assign unused_inputs = ^{ball_y, speed_curr_x};

    // 10-bit add on purpose: matches the ball logic's own coordinate width.
    assign ball_right   = ball_x + BALL_WIDTH;
    assign left_miss    = (ball_x < LEFT_MISS);
    assign right_miss   = (ball_right > RIGHT_MISS);
    assign restart_fall = restart_prev_q & ~restart_n;
    assign p1_inc       = p1_score_q + 4'd1;
    assign p2_inc       = p2_score_q + 4'd1;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        point_p1_d = 1'b0;
        point_p2_d = 1'b0;
        winner_d   = winner_q;
        arm_d      = arm_q;

        case (state_q)
            // The arm flag enters each serve state clear and only sets after
            // the server has been seen with both buttons released, so a button
            // held through the point cannot fire the next serve.
            P1_SERVE: begin
                if (arm_q && (!p1u || !p1d)) begin
                    state_d = PLAYING;
                    arm_d   = 1'b0;
                end else if (p1u && p1d) begin
                    arm_d = 1'b1;
                end
            end
            P2_SERVE: begin
                if (arm_q && (!p2u || !p2d)) begin
                    state_d = PLAYING;
                    arm_d   = 1'b0;
                end else if (p2u && p2d) begin
                    arm_d = 1'b1;
                end
            end
            PLAYING: begin
                arm_d = 1'b0;
                // Left miss has priority so a simultaneous miss scores once.
                if (left_miss) begin
                    p2_score_d = p2_inc;
                    point_p2_d = 1'b1;
                    if (p2_inc == WIN_SCORE) begin
                        state_d  = DONE;
                        winner_d = 2'd2;
                    end else begin
                        state_d = P1_SERVE;
                    end
                end else if (right_miss) begin
                    p1_score_d = p1_inc;
                    point_p1_d = 1'b1;
                    if (p1_inc == WIN_SCORE) begin
                        state_d  = DONE;
                        winner_d = 2'd1;
                    end else begin
                        state_d = P2_SERVE;
                    end
                end
            end
            DONE: begin
                arm_d = 1'b0;
                if (restart_fall) begin
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                    winner_d   = 2'd0;
                    state_d    = P1_SERVE;
                end
            end
            default: state_d = P1_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= P1_SERVE;
            p1_score_q     <= 4'd0;
            p2_score_q     <= 4'd0;
            point_p1_q     <= 1'b0;
            point_p2_q     <= 1'b0;
            winner_q       <= 2'd0;
            arm_q          <= 1'b0;
            restart_prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of the others.
            state_q        <= state_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            point_p1_q     <= point_p1_d;
            point_p2_q     <= point_p2_d;
            winner_q       <= winner_d;
            arm_q          <= arm_d;
            restart_prev_q <= restart_n;
        end
    end

    assign game_state = state_q;
    assign p1_score   = p1_score_q;
    assign p2_score   = p2_score_q;
    assign point_p1   = point_p1_q;
    assign point_p2   = point_p2_q;
    assign winner     = winner_q;

`ifdef PONG_RALLY_CNT_EN
    logic       sign_prev_q;
    logic [7:0] rally_q, rally_d;
    logic [7:0] max_q, max_d;

    // A paddle hit reverses the ball, which shows up as a sign flip of the
    // x speed relative to the previous frame.
    always_comb begin
        rally_d = rally_q;
        max_d   = max_q;
        if (state_q == PLAYING) begin
            if (left_miss || right_miss) begin
                max_d   = (rally_q > max_q) ? rally_q : max_q;
                rally_d = 8'd0;
            end else if ((speed_curr_x[9] != sign_prev_q) && (rally_q != 8'hFF)) begin
                rally_d = rally_q + 8'd1;
            end
        end else if ((state_q == DONE) && restart_fall) begin
            rally_d = 8'd0;
            max_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_prev_q <= 1'b0;
            rally_q     <= 8'd0;
            max_q       <= 8'd0;
        end else begin
            sign_prev_q <= speed_curr_x[9];
            rally_q     <= rally_d;
            max_q       <= max_d;
        end
    end

    assign rally_cnt = rally_q;
    assign max_rally = max_q;
`else
    assign rally_cnt = 8'd0;
    assign max_rally = 8'd0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl. Expected output snapshots are
// pushed to a scoreboard queue as each step is driven and popped/compared
// once the DUT has produced its response. Rally expectations follow the
// PONG_RALLY_CNT_EN macro.

module tb_pong_game_ctrl;

    localparam logic [9:0] SPD_POS = 10'd3;
    localparam logic [9:0] SPD_NEG = 10'h3FD;  // -3

    logic       clk = 1'b0;
    logic       reset;
    logic       p1u, p1d, p2u, p2d, restart_n;
    logic [9:0] ball_x, ball_y, speed_curr_x;
    logic [1:0] game_state, winner;
    logic [3:0] p1_score, p2_score;
    logic       point_p1, point_p2;
    logic [7:0] rally_cnt, max_rally;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .p1u          (p1u),
        .p1d          (p1d),
        .p2u          (p2u),
        .p2d          (p2d),
        .restart_n    (restart_n),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .speed_curr_x (speed_curr_x),
        .game_state   (game_state),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .point_p1     (point_p1),
        .point_p2     (point_p2),
        .winner       (winner),
        .rally_cnt    (rally_cnt),
        .max_rally    (max_rally)
    );

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       pt1;
        logic       pt2;
        logic [1:0] win;
        logic [7:0] rally;
        logic [7:0] maxr;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Expected-state tracking, updated by hand at each directed step.
    logic [1:0] e_state, e_win;
    logic [3:0] e_p1, e_p2;
    logic       e_pt1, e_pt2;
    logic [7:0] e_rally, e_max;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.st  = e_state;
        e.s1  = e_p1;
        e.s2  = e_p2;
        e.pt1 = e_pt1;
        e.pt2 = e_pt2;
        e.win = e_win;
`ifdef PONG_RALLY_CNT_EN
        e.rally = e_rally;
        e.maxr  = e_max;
`else
        e.rally = 8'd0;
        e.maxr  = 8'd0;
`endif
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            cmp({e.tag, ".state"},  {6'd0, game_state}, {6'd0, e.st});
            cmp({e.tag, ".p1"},     {4'd0, p1_score},   {4'd0, e.s1});
            cmp({e.tag, ".p2"},     {4'd0, p2_score},   {4'd0, e.s2});
            cmp({e.tag, ".pt1"},    {7'd0, point_p1},   {7'd0, e.pt1});
            cmp({e.tag, ".pt2"},    {7'd0, point_p2},   {7'd0, e.pt2});
            cmp({e.tag, ".winner"}, {6'd0, winner},     {6'd0, e.win});
            cmp({e.tag, ".rally"},  rally_cnt,          e.rally);
            cmp({e.tag, ".max"},    max_rally,          e.maxr);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        push(tag);
        tick();
        check();
    endtask

    initial begin
        reset        = 1'b0;
        p1u          = 1'b1;
        p1d          = 1'b1;
        p2u          = 1'b1;
        p2d          = 1'b1;
        restart_n    = 1'b1;
        ball_x       = 10'd300;
        ball_y       = 10'd240;
        speed_curr_x = SPD_POS;
        e_state = 2'd0; e_p1 = 4'd0; e_p2 = 4'd0; e_pt1 = 1'b0; e_pt2 = 1'b0;
        e_win = 2'd0; e_rally = 8'd0; e_max = 8'd0;

        #2;
        push("reset");
        check();
        tick();
        tick();
        reset = 1'b1;

        // First serve: buttons seen released, then one press.
        step("arm_p1");
        p1d = 1'b0; e_state = 2'd2;
        step("serve_p1");
        step("hold_p1d");
        p1d = 1'b1;

        // Three paddle hits, then a left miss with p1u held down.
        speed_curr_x = SPD_NEG; e_rally = 8'd1; step("hit1");
        speed_curr_x = SPD_POS; e_rally = 8'd2; step("hit2");
        speed_curr_x = SPD_NEG; e_rally = 8'd3; step("hit3");
        p1u = 1'b0; ball_x = 10'd139;
        e_p2 = 4'd1; e_pt2 = 1'b1; e_state = 2'd0; e_max = 8'd3; e_rally = 8'd0;
        step("left_miss");
        ball_x = 10'd300; speed_curr_x = SPD_POS; e_pt2 = 1'b0;
        step("pulse_clear");
        step("p1u_held");
        p1u = 1'b1; step("arm_again");
        p1u = 1'b0; e_state = 2'd2; step("serve_again");
        p1u = 1'b1;

        // One-hit rally, right boundary, then right miss.
        speed_curr_x = SPD_NEG; e_rally = 8'd1; step("hit_one");
        ball_x = 10'd495; step("edge_no_miss");
        ball_x = 10'd496; e_p1 = 4'd1; e_pt1 = 1'b1; e_state = 2'd1; e_rally = 8'd0;
        step("right_miss");
        ball_x = 10'd300; speed_curr_x = SPD_POS; e_pt1 = 1'b0; p1d = 1'b0;
        step("p2_arm");
        step("p1_ignored");
        p1d = 1'b1;

        // P1 scores up to the win; restart_n goes low while still playing.
        for (int k = 2; k <= 5; k++) begin
            p2d = 1'b0; e_state = 2'd2; step("serve_p2");
            p2d = 1'b1;
            if (k == 5) restart_n = 1'b0;
            ball_x = 10'd496;
            e_p1 = 4'(k); e_pt1 = 1'b1;
            e_state = (k == 5) ? 2'd3 : 2'd1;
            e_win   = (k == 5) ? 2'd1 : 2'd0;
            step("p1_point");
            ball_x = 10'd300; e_pt1 = 1'b0;
            step("settle");
        end

        // Done holds against misses and buttons.
        ball_x = 10'd496; step("done_right");
        ball_x = 10'd139; step("done_left");
        ball_x = 10'd300; p1d = 1'b0; p2u = 1'b0; step("done_buttons");
        p1d = 1'b1; p2u = 1'b1;
        step("restart_held");
        restart_n = 1'b1; step("restart_release");
        restart_n = 1'b0;
        e_state = 2'd0; e_p1 = 4'd0; e_p2 = 4'd0; e_win = 2'd0; e_max = 8'd0;
        step("restart");
        restart_n = 1'b1;

        // New match: one point, then reset asynchronously mid-rally.
        step("arm_p1b");
        p1d = 1'b0; e_state = 2'd2; step("serve_p1b");
        p1d = 1'b1;
        speed_curr_x = SPD_NEG; e_rally = 8'd1; step("hit_b");
        ball_x = 10'd139; e_p2 = 4'd1; e_pt2 = 1'b1; e_state = 2'd0;
        e_max = 8'd1; e_rally = 8'd0;
        step("left_miss_b");
        ball_x = 10'd300; speed_curr_x = SPD_POS; e_pt2 = 1'b0;
        step("arm_p1c");
        p1u = 1'b0; e_state = 2'd2; step("serve_p1c");
        p1u = 1'b1;
        speed_curr_x = SPD_NEG; e_rally = 8'd1; step("hit_c");
        #3;
        reset = 1'b0;
        #1;
        e_state = 2'd0; e_p1 = 4'd0; e_p2 = 4'd0; e_pt1 = 1'b0; e_pt2 = 1'b0;
        e_win = 2'd0; e_rally = 8'd0; e_max = 8'd0;
        push("async_reset");
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
